vga_timing_fb_param: RTL and testbench
======================================

# vga_timing_fb_param

Parametrised VGA timing generator and framebuffer reader that replaces the fixed 640x480 horizontal/vertical counters, sync generator and address counter in the VGA path. It produces hsync/vsync/n_blank from configurable porch and sync widths. It generates framebuffer read addresses with power-of-two pixel replication and a relocatable base address. It compensates for a configurable memory read latency so that sync, blank, coordinates and RGB leave the block cycle-aligned.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48: horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33: vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0: active level of hsync / vsync
- SCALE_SHIFT, 0: each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels; H_ACTIVE and V_ACTIVE are multiples of 2^SCALE_SHIFT
- ADDR_W, 18: framebuffer address width
- RD_LAT, 1: framebuffer read latency in cycles, ≥1
- clock_25  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run timing; low parks the raster
- fb_base  in  ADDR_W  framebuffer base address; sampled at frame start
- data_ram  in  24  pixel data {R,G,B}, valid RD_LAT cycles after address/rd_en
- address  out  ADDR_W  framebuffer read address
- rd_en  out  1  read strobe, high while address refers to a visible pixel
- red / green / blue  out  8 each  pixel colour, 0 outside the visible area
- hsync / vsync  out  1  sync outputs at HS_POL / VS_POL levels
- n_blank  out  1  high during the visible area
- x / y  out  10  coordinates of the pixel currently on red/green/blue
- frame_start  out  1  one-cycle pulse, aligned with pixel (0,0) on the outputs

## Operation
- Totals: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP. Counters h: 0..H_TOT-1, wrap to 0. Counter v increments when h wraps and wraps to 0 after V_TOT-1.
- Raw visible = (h < H_ACTIVE) && (v < V_ACTIVE).
- Raw hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC. Raw vsync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- Address generation is incremental and uses no multiplier. It keeps col, row_base and base_lat registers.
  - address = base_lat + row_base + col, registered.
  - col increments once every 2^SCALE_SHIFT visible pixels and clears at h wrap.
  - At the end of visible line v, row_base += H_ACTIVE>>SCALE_SHIFT only if v[SCALE_SHIFT-1:0] is all ones. With SCALE_SHIFT=0 it advances every line.
  - row_base clears, and base_lat ← fb_base, at the counter transition to (h=0, v=0).
- rd_en is the registered raw visible. address holds its last value while rd_en is low.
- Pipeline: hsync, vsync, visible, h, v and the frame-start flag pass through a delay line so that every output is registered and lags the counters by L = RD_LAT+2 cycles.
- red/green/blue = data_ram[23:16]/[15:8]/[7:0] when the delayed visible is high, else 0. They are registered at the same stage as the other outputs.
- enable low:
  - Counters, col and row_base clear synchronously; the pipeline flushes with idle values.
  - Outputs: rd_en 0, n_blank 0, rgb 0, syncs inactive.
  - On re-enable, the raster restarts at (0,0) and base_lat is re-sampled.

## Timing
- Reset (async, low) values: h=v=0, address 0, rd_en 0, n_blank 0, rgb 0, x=y=0, frame_start 0, hsync=~HS_POL, vsync=~VS_POL. The pipeline clears to idle.
- Pixel at counter (h,v) appears on x/y/rgb/n_blank/syncs exactly L cycles after the counters held (h,v).
- With enable high, the first active edge after reset release has counters at (0,0). frame_start pulses L cycles later.
- A change to fb_base mid-frame has no effect until the next frame start.
- Reset asserted mid-frame clears everything immediately. No partial pulses extend past reset assertion.
- Address range per frame is base_lat .. base_lat + (H_ACTIVE>>S)*(V_ACTIVE>>S) - 1, modulo 2^ADDR_W; there is no overflow check.

## Test plan
- **Default parameters, RD_LAT=1 (L=3).** Stimulus: model RAM returns data = address. Required:
  - Hsync period 800 cycles with an active-low width of 96.
  - Vsync 2 lines (1600 cycles) every 525 lines.
  - n_blank high for 640 consecutive cycles per visible line.
  - frame_start 3 cycles after counter (0,0).
- **Latency alignment, RD_LAT=3.** Required: rgb equals the address issued for the same (x,y) on every visible pixel. Sync edges shift by exactly 5 cycles relative to counters.
- **SCALE_SHIFT=1.** Required:
  - Line 0 addresses 0,0,1,1,…,319,319.
  - Line 1 repeats line 0; line 2 starts at 320.
  - Last visible address is 76799; rd_en count per frame is 307200.
- **fb_base mid-frame.** Stimulus: fb_base=0 at start, changed to 0x10000 at v=200. Required: remaining addresses stay in 0..; the next frame starts at 0x10000.
- **enable mid-line.** Stimulus: deassert at h=300, v=10; reassert 50 cycles later. Required: n_blank, rgb and rd_en at 0 within L cycles of the drop. Counters restart at (0,0) and frame_start pulses L cycles after re-enable.
- **Reset mid-frame.** Stimulus: reset low at (h=700, v=490). Required: all outputs take their reset values in the same cycle and hsync is at ~HS_POL. The raster resumes from (0,0) after release.

Source files
------------

// File: rtl/vga_timing_fb_param_if.sv
// Framebuffer read port: the timing generator drives address/rd_en and
// receives pixel data RD_LAT cycles later.
interface vga_timing_fb_param_if #(
    parameter int unsigned ADDR_W = 18
);
    logic [ADDR_W-1:0] address;
    logic              rd_en;
    logic [23:0]       data_ram;

    modport master (
        output address,
        output rd_en,
        input  data_ram
    );

    modport slave (
        input  address,
        input  rd_en,
        output data_ram
    );
endinterface

// File: rtl/vga_timing_fb_param.sv
// Parametrised VGA raster generator with framebuffer read-address generation.
// Sync, blank, coordinates and RGB all leave the block L = RD_LAT + 2 cycles
// after the raster counters, so they line up with the memory's read data.
module vga_timing_fb_param #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned RD_LAT      = 1
) (
    input  logic                     clock_25,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [ADDR_W-1:0]        fb_base,
    vga_timing_fb_param_if.master    fb,
    output logic [7:0]               red,
    output logic [7:0]               green,
    output logic [7:0]               blue,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     n_blank,
    output logic [9:0]               x,
    output logic [9:0]               y,
    output logic                     frame_start
);

    localparam int unsigned H_TOT      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW         = $clog2(H_TOT);
    localparam int unsigned VW         = $clog2(V_TOT);
    localparam int unsigned L          = RD_LAT + 2;
    localparam int unsigned SCALE_MASK = (32'd1 << SCALE_SHIFT) - 32'd1;
    localparam int unsigned COLS       = H_ACTIVE >> SCALE_SHIFT;

    // Sync flags are stored as "active" bits so an all-zero stage is idle.
    typedef struct packed {
        logic       fs;
        logic       vis;
        logic       hs;
        logic       vs;
        logic [9:0] px;
        logic [9:0] py;
    } stage_t;

    logic [HW-1:0]     h_q;
    logic [VW-1:0]     v_q;
    logic              h_last;
    logic              v_last;
    logic              raw_vis;
    logic              raw_hs;
    logic              raw_vs;
    logic              raw_fs;
    logic              col_inc;
    logic              line_end;
    logic              row_adv;
    logic [ADDR_W-1:0] col_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] base_lat_q;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] address_q;
    logic              rd_en_q;
    stage_t            stage_in;
    stage_t [L-1:0]    pipe_q;
    logic [23:0]       rgb_q;

    assign h_last = (32'(h_q) == H_TOT - 1);
    assign v_last = (32'(v_q) == V_TOT - 1);

    // Raster counters; disabling parks them at (0,0) so re-enable restarts the frame.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (!enable) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_last ? '0 : h_q + HW'(1);
            if (h_last) begin
                v_q <= v_last ? '0 : v_q + VW'(1);
            end
        end
    end

    // Raw (undelayed) raster decode.
    always_comb begin
        raw_vis  = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
        raw_hs   = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
        raw_vs   = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
        raw_fs   = (h_q == '0) && (v_q == '0);
        // Last screen pixel of a framebuffer pixel column / last screen line of a row.
        col_inc  = raw_vis && ((32'(h_q) & SCALE_MASK) == SCALE_MASK);
        line_end = (32'(h_q) == H_ACTIVE - 1) && (32'(v_q) < V_ACTIVE);
        row_adv  = line_end && ((32'(v_q) & SCALE_MASK) == SCALE_MASK);
    end

    // Incremental address state: column, row offset and latched frame base.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_base_q <= '0;
            base_lat_q <= '0;
        end else if (!enable) begin
            col_q      <= '0;
            row_base_q <= '0;
        end else begin
            if (h_last) begin
                col_q <= '0;
            end else if (col_inc) begin
                col_q <= col_q + ADDR_W'(1);
            end
            if (h_last && v_last) begin
                row_base_q <= '0;
            end else if (row_adv) begin
                row_base_q <= row_base_q + ADDR_W'(COLS);
            end
            if (raw_fs) begin
                base_lat_q <= fb_base;
            end
        end
    end

    // At (0,0) the base is taken straight from fb_base so the very first frame
    // after reset or re-enable already uses the current base.
    always_comb begin
        base_cur  = raw_fs ? fb_base : base_lat_q;
        addr_next = base_cur + row_base_q + col_q;
    end

    // Read strobe and address; the address holds outside the visible area.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            address_q <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            rd_en_q <= enable && raw_vis;
            if (enable && raw_vis) begin
                address_q <= addr_next;
            end
        end
    end

    assign fb.address = address_q;
    assign fb.rd_en   = rd_en_q;

    // Stage fed into the delay line; idle while disabled so the pipe flushes.
    always_comb begin
        stage_in = '0;
        if (enable) begin
            stage_in.fs  = raw_fs;
            stage_in.vis = raw_vis;
            stage_in.hs  = raw_hs;
            stage_in.vs  = raw_vs;
            stage_in.px  = 10'(h_q);
            stage_in.py  = 10'(v_q);
        end
    end

    // Timing delay line: stage 0 lines up with the address, stage L-1 with the outputs.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[L-2:0], stage_in};
        end
    end

    // Read data is valid while stage L-2 is current; capture it alongside stage L-1.
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pipe_q[L-2].vis ? fb.data_ram : 24'd0;
        end
    end

    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign n_blank     = pipe_q[L-1].vis;
    assign hsync       = pipe_q[L-1].hs ? HS_POL : ~HS_POL;
    assign vsync       = pipe_q[L-1].vs ? VS_POL : ~VS_POL;
    assign x           = pipe_q[L-1].px;
    assign y           = pipe_q[L-1].py;
    assign frame_start = pipe_q[L-1].fs;

endmodule

// File: tb/tb_vga_timing_fb_param.sv
// Randomised scoreboard bench for vga_timing_fb_param on a small raster
// (24x12 totals, 2x pixel replication, RD_LAT=2, vsync active-high).
module tb_vga_timing_fb_param;

    localparam int unsigned H_ACTIVE    = 16;
    localparam int unsigned H_FP        = 2;
    localparam int unsigned H_SYNC      = 3;
    localparam int unsigned H_BP        = 3;
    localparam int unsigned V_ACTIVE    = 8;
    localparam int unsigned V_FP        = 1;
    localparam int unsigned V_SYNC      = 2;
    localparam int unsigned V_BP        = 1;
    localparam bit          HS_POL      = 1'b0;
    localparam bit          VS_POL      = 1'b1;
    localparam int unsigned SCALE_SHIFT = 1;
    localparam int unsigned ADDR_W      = 18;
    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned L           = RD_LAT + 2;
    localparam int unsigned H_TOT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned FRAME       = H_TOT * V_TOT;
    localparam int          NCYC        = 2600;

    logic              clock_25 = 1'b0;
    logic              reset    = 1'b0;
    logic              enable   = 1'b0;
    logic [ADDR_W-1:0] fb_base  = '0;
    logic [7:0]        red, green, blue;
    logic              hsync, vsync, n_blank, frame_start;
    logic [9:0]        x, y;

    vga_timing_fb_param_if #(.ADDR_W(ADDR_W)) fb ();

    vga_timing_fb_param #(
        .H_ACTIVE   (H_ACTIVE),
        .H_FP       (H_FP),
        .H_SYNC     (H_SYNC),
        .H_BP       (H_BP),
        .V_ACTIVE   (V_ACTIVE),
        .V_FP       (V_FP),
        .V_SYNC     (V_SYNC),
        .V_BP       (V_BP),
        .HS_POL     (HS_POL),
        .VS_POL     (VS_POL),
        .SCALE_SHIFT(SCALE_SHIFT),
        .ADDR_W     (ADDR_W),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clock_25   (clock_25),
        .reset      (reset),
        .enable     (enable),
        .fb_base    (fb_base),
        .fb         (fb),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .hsync      (hsync),
        .vsync      (vsync),
        .n_blank    (n_blank),
        .x          (x),
        .y          (y),
        .frame_start(frame_start)
    );

    always #5 clock_25 = ~clock_25;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [23:0] pix_of(input logic [ADDR_W-1:0] a);
        return 24'(a) ^ 24'hC35A00;
    endfunction

    // Read-latency memory model; unread cycles return junk.
    logic [ADDR_W-1:0] ram_addr [RD_LAT];
    logic              ram_vld  [RD_LAT];
    logic [23:0]       junk;
    always @(posedge clock_25) begin
        ram_addr[0] <= fb.address;
        ram_vld[0]  <= fb.rd_en;
        junk        <= 24'($urandom);
        for (int i = 1; i < RD_LAT; i++) begin
            ram_addr[i] <= ram_addr[i-1];
            ram_vld[i]  <= ram_vld[i-1];
        end
    end
    assign fb.data_ram = (ram_vld[RD_LAT-1] === 1'b1) ? pix_of(ram_addr[RD_LAT-1]) : junk;

    int cyc = 0;
    always @(posedge clock_25) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        nb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] rgb;
    } vid_t;

    typedef struct {
        int                due;
        logic              rd;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    vid_t vq[$];
    rd_t  rq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations due this cycle and compares against DUT outputs.
    always begin
        vid_t e;
        rd_t  r;
        @(posedge clock_25);
        #1;
        while (vq.size() > 0 && vq[0].due <= cyc) begin
            e = vq.pop_front();
            if (e.due != cyc) begin
                chk("vid_due", 32'(cyc), 32'(e.due));
            end else begin
                chk("x", 32'(x), 32'(e.x));
                chk("y", 32'(y), 32'(e.y));
                chk("n_blank", 32'(n_blank), 32'(e.nb));
                chk("hsync", 32'(hsync), 32'(e.hs));
                chk("vsync", 32'(vsync), 32'(e.vs));
                chk("frame_start", 32'(frame_start), 32'(e.fs));
                chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
            end
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            if (r.due != cyc) begin
                chk("rd_due", 32'(cyc), 32'(r.due));
            end else begin
                chk("rd_en", 32'(fb.rd_en), 32'(r.rd));
                chk("address", 32'(fb.address), 32'(r.addr));
            end
        end
    end

    // Reference model state: position within the frame and the frame's base.
    int                pos        = 0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [ADDR_W-1:0] last_addr  = '0;

    // Predict this cycle's raster position and queue its outputs.
    task automatic step();
        vid_t e;
        rd_t  r;
        int   h, v;
        bit   vis;
        logic [ADDR_W-1:0] a;
        e = '{due: cyc + int'(L), x: 10'd0, y: 10'd0, nb: 1'b0, hs: !HS_POL, vs: !VS_POL,
              fs: 1'b0, rgb: 24'd0};
        r = '{due: cyc + 1, rd: 1'b0, addr: last_addr};
        if (enable) begin
            h   = pos % int'(H_TOT);
            v   = pos / int'(H_TOT);
            vis = (h < int'(H_ACTIVE)) && (v < int'(V_ACTIVE));
            if (pos == 0) frame_base = fb_base;
            e.x  = 10'(h);
            e.y  = 10'(v);
            e.nb = vis;
            e.fs = (pos == 0);
            if (h >= int'(H_ACTIVE + H_FP) && h < int'(H_ACTIVE + H_FP + H_SYNC)) e.hs = HS_POL;
            if (v >= int'(V_ACTIVE + V_FP) && v < int'(V_ACTIVE + V_FP + V_SYNC)) e.vs = VS_POL;
            if (vis) begin
                a = ADDR_W'(32'(frame_base) + 32'((v >> SCALE_SHIFT) * (H_ACTIVE >> SCALE_SHIFT))
                            + 32'(h >> SCALE_SHIFT));
                last_addr = a;
                e.rgb  = pix_of(a);
                r.rd   = 1'b1;
                r.addr = a;
            end
            pos = (pos + 1) % int'(FRAME);
        end else begin
            pos = 0;
        end
        vq.push_back(e);
        rq.push_back(r);
    endtask

    task automatic chk_reset_vals();
        chk("rst_address", 32'(fb.address), 32'd0);
        chk("rst_rd_en", 32'(fb.rd_en), 32'd0);
        chk("rst_n_blank", 32'(n_blank), 32'd0);
        chk("rst_rgb", 32'({red, green, blue}), 32'd0);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'(!HS_POL));
        chk("rst_vsync", 32'(vsync), 32'(!VS_POL));
    endtask

    // Asynchronous reset pulse mid-cycle; returns at a negedge just after release.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_vals();
        vq.delete();
        rq.delete();
        pos       = 0;
        last_addr = '0;
        repeat (2) @(negedge clock_25);
        reset = 1'b1;
    endtask

    initial begin
        int  h, v, dis_left, nchg;
        bit  drop1_done, rst1_done, rst2_done;
        dis_left   = 0;
        nchg       = 0;
        drop1_done = 1'b0;
        rst1_done  = 1'b0;
        rst2_done  = 1'b0;
        repeat (3) @(negedge clock_25);
        chk_reset_vals();
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < NCYC; i++) begin
            h = pos % int'(H_TOT);
            v = pos / int'(H_TOT);
            if (dis_left > 0) begin
                dis_left--;
                enable = (dis_left == 0);
            end else if ((i >= 400 && !drop1_done && h == 10 && v == 3) ||
                         ($urandom_range(0, 199) == 0)) begin
                enable     = 1'b0;
                dis_left   = int'($urandom_range(2, 15));
                drop1_done = 1'b1;
            end
            if (enable && i >= 1200 && !rst1_done && h == 20 && v == 9) begin
                rst1_done = 1'b1;
                do_reset();
            end else if (enable && i >= 2200 && !rst2_done) begin
                rst2_done = 1'b1;
                do_reset();
            end
            if (enable && h == 5 && v == int'(V_ACTIVE / 2)) begin
                case (nchg)
                    0:       fb_base = 18'h10000;
                    1:       fb_base = 18'h3FFF5;
                    default: fb_base = ADDR_W'($urandom);
                endcase
                nchg++;
            end
            step();
            @(negedge clock_25);
        end
        enable = 1'b0;
        repeat (L + 3) @(negedge clock_25);
        chk("queue_drain", 32'(vq.size() + rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
